// File: rtl/pipe_dbus.sv
// pipe_dbus: MEM-stage data bus for the pipelined CPU.
// Decodes the word address into a data RAM, an LED register, a synchronized
// switch port and a reloadable down-counting timer with interrupt.
module pipe_dbus #(
  parameter int unsigned DMEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        timer_irq
);

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_LED,
    SEL_SW,
    SEL_TCTRL,
    SEL_TLOAD,
    SEL_TCOUNT
  } sel_t;

  // RAM word-index bits above DMEM_AW (up to bit 11) must be zero for a hit
  localparam logic [11:0] IDX_HI_MASK = 12'(12'hFFF << (DMEM_AW + 2));

  sel_t                 sel;
  logic [DMEM_AW-1:0]   ram_idx;
  logic [31:0]          mem [2**DMEM_AW];

  logic [15:0]          led_q;
  logic [15:0]          sw_meta;
  logic [15:0]          sw_sync;

  logic                 t_en;
  logic                 t_auto;
  logic                 t_irq_en;
  logic                 t_irq_status;
  logic [31:0]          t_load;
  logic [31:0]          t_count;

  logic                 wr_led;
  logic                 wr_tctrl;
  logic                 wr_tload;
  logic                 expire;

  // byte-lane bits are not part of any word access
  logic                 unused_addr_lsb;
  assign unused_addr_lsb = ^aluout[1:0];

  assign ram_idx  = aluout[DMEM_AW+1:2];
  assign wr_led   = MemWrite && (sel == SEL_LED);
  assign wr_tctrl = MemWrite && (sel == SEL_TCTRL);
  assign wr_tload = MemWrite && (sel == SEL_TLOAD);
  assign expire   = t_en && (t_count == 32'd1);

  assign led       = led_q;
  assign timer_irq = t_irq_status & t_irq_en;

  // Address decode into one target (or none)
  always_comb begin
    sel = SEL_NONE;
    if (aluout[31:16] == 16'h0000) begin
      if (aluout[15:12] == 4'h0) begin
        if ((aluout[11:0] & IDX_HI_MASK) == '0) sel = SEL_RAM;
      end else if (aluout[15:12] == 4'hF) begin
        case (aluout[11:2])
          10'h000: sel = SEL_LED;
          10'h001: sel = SEL_SW;
          10'h004: sel = SEL_TCTRL;
          10'h005: sel = SEL_TLOAD;
          10'h006: sel = SEL_TCOUNT;
          default: sel = SEL_NONE;
        endcase
      end
    end
  end

  // Data RAM write port; contents survive reset
  always_ff @(posedge clk) begin
    if (MemWrite && (sel == SEL_RAM)) mem[ram_idx] <= writedata;
  end

  // LED register and two-flop switch synchronizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q   <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      if (wr_led) led_q <= writedata[15:0];
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  // Timer control bits; an expiry set overrides a same-edge W1C clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_en         <= 1'b0;
      t_auto       <= 1'b0;
      t_irq_en     <= 1'b0;
      t_irq_status <= 1'b0;
    end else begin
      if (wr_tctrl) begin
        t_en     <= writedata[0];
        t_auto   <= writedata[1];
        t_irq_en <= writedata[3];
      end
      if (expire)                        t_irq_status <= 1'b1;
      else if (wr_tctrl && writedata[2]) t_irq_status <= 1'b0;
    end
  end

  // Reload register and counter; a TLOAD write beats expiry reload and decrement
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_load  <= '0;
      t_count <= '0;
    end else begin
      if (wr_tload) begin
        t_load  <= writedata;
        t_count <= writedata;
      end else if (expire) begin
        t_count <= t_auto ? t_load : '0;
      end else if (t_en && (t_count != '0)) begin
        t_count <= t_count - 32'd1;
      end
    end
  end

  // Combinational load data
  always_comb begin
    readdata = '0;
    case (sel)
      SEL_RAM:    readdata = mem[ram_idx];
      SEL_LED:    readdata = {16'h0000, led_q};
      SEL_SW:     readdata = {16'h0000, sw_sync};
      SEL_TCTRL:  readdata = {28'h0000000, t_irq_en, t_irq_status, t_auto, t_en};
      SEL_TLOAD:  readdata = t_load;
      SEL_TCOUNT: readdata = t_count;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_pipe_dbus.sv
// tb_pipe_dbus: directed and randomized checks of pipe_dbus against a
// behavioural model of the bus map, switch sync and timer.
module tb_pipe_dbus;

  localparam int unsigned AW = 8;

  logic        clk;
  logic        rst;
  logic        MemWrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw;
  logic [15:0] led;
  logic        timer_irq;

  pipe_dbus #(.DMEM_AW(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .aluout    (aluout),
    .writedata (writedata),
    .readdata  (readdata),
    .sw        (sw),
    .led       (led),
    .timer_irq (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // ---------------- reference model ----------------
  logic [31:0] m_ram [2**AW];
  logic [15:0] m_led;
  logic [15:0] m_sw_seen [$];   // switch samples, newest first
  logic        m_en, m_auto, m_ien, m_st;
  logic [31:0] m_load, m_cnt;

  logic [15:0] cur_sw;
  logic        last_irq;

  localparam int R_NONE = 0, R_RAM = 1, R_LED = 2, R_SW = 3,
                 R_TCTRL = 4, R_TLOAD = 5, R_TCOUNT = 6;

  function automatic int region(input logic [31:0] a);
    if (a[31:16] != 16'h0) return R_NONE;
    if (a[15:12] == 4'h0) return ((a[11:0] >> (AW + 2)) == 12'h0) ? R_RAM : R_NONE;
    if (a[15:12] != 4'hF) return R_NONE;
    case (a[11:0] & 12'hFFC)
      12'h000: return R_LED;
      12'h004: return R_SW;
      12'h010: return R_TCTRL;
      12'h014: return R_TLOAD;
      12'h018: return R_TCOUNT;
      default: return R_NONE;
    endcase
  endfunction

  function automatic logic [15:0] sw_visible();
    // the synchronizer shows the sample taken two edges ago
    if (m_sw_seen.size() >= 2) return m_sw_seen[1];
    return 16'h0;
  endfunction

  function automatic logic [31:0] exp_read(input logic [31:0] a);
    case (region(a))
      R_RAM:    return m_ram[a[AW+1:2]];
      R_LED:    return {16'h0, m_led};
      R_SW:     return {16'h0, sw_visible()};
      R_TCTRL:  return {28'h0, m_ien, m_st, m_auto, m_en};
      R_TLOAD:  return m_load;
      R_TCOUNT: return m_cnt;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 16'h0;
    m_sw_seen.delete();
    m_en = 1'b0; m_auto = 1'b0; m_ien = 1'b0; m_st = 1'b0;
    m_load = 32'h0; m_cnt = 32'h0;
  endtask

  task automatic model_edge(input logic we, input logic [31:0] a,
                            input logic [31:0] wd, input logic [15:0] swv);
    int          r;
    logic        fires;
    r = region(a);
    fires = m_en && (m_cnt == 32'd1);
    m_sw_seen.push_front(swv);
    if (m_sw_seen.size() > 2) void'(m_sw_seen.pop_back());
    if (we && r == R_RAM) m_ram[a[AW+1:2]] = wd;
    if (we && r == R_LED) m_led = wd[15:0];
    // counter: explicit load first, then expiry, then plain countdown
    if (we && r == R_TLOAD) begin
      m_load = wd;
      m_cnt  = wd;
    end else if (fires) begin
      m_cnt = m_auto ? m_load : 32'h0;
    end else if (m_en && m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end
    if (fires) m_st = 1'b1;
    else if (we && r == R_TCTRL && wd[2]) m_st = 1'b0;
    if (we && r == R_TCTRL) begin
      m_en   = wd[0];
      m_auto = wd[1];
      m_ien  = wd[3];
    end
  endtask

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // One bus cycle: drive after the falling edge, check mid-cycle, model the rising edge
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd);
    @(negedge clk);
    MemWrite  = we;
    aluout    = a;
    writedata = wd;
    sw        = cur_sw;
    #1;
    rd       = readdata;
    last_irq = timer_irq;
    check_eq("readdata", readdata, exp_read(a));
    check_eq("led", {16'h0, led}, {16'h0, m_led});
    check_eq("timer_irq", {31'h0, timer_irq}, {31'h0, m_st & m_ien});
    @(posedge clk);
    model_edge(we, a, wd, cur_sw);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    cycle(1'b1, a, d, rd);
  endtask

  task automatic rd_bus(input logic [31:0] a, output logic [31:0] rd);
    cycle(1'b0, a, 32'h0, rd);
  endtask

  // Asynchronous reset mid-cycle; returns count and irq seen just before it
  task automatic async_reset(output logic [31:0] pre_cnt, output logic pre_irq);
    @(negedge clk);
    MemWrite = 1'b0;
    aluout   = 32'h0000_F018;
    #1;
    pre_cnt = readdata;
    pre_irq = timer_irq;
    rst = 1'b0;
    #1;
    model_reset();
    check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_irq", {31'h0, timer_irq}, 32'h0);
    check_eq("rst_tcount", readdata, 32'h0);
    aluout = 32'h0000_F010; #1;
    check_eq("rst_tctrl", readdata, 32'h0);
    aluout = 32'h0000_F014; #1;
    check_eq("rst_tload", readdata, 32'h0);
    aluout = 32'h0000_0010; #1;
    check_eq("rst_ram_kept", readdata, 32'hDEADBEEF);
    aluout = 32'h0000_0000; #1;
    check_eq("rst_ram_word0", readdata, 32'hCAFE0000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b0, aluout, writedata, sw);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [31:0] r;
  logic [31:0] pc;
  logic        pi;
  int unsigned seq_per [6] = '{5, 4, 3, 2, 1, 5};
  int unsigned seq_one [4] = '{3, 2, 1, 0};

  initial begin
    rst = 1'b0; MemWrite = 1'b0; aluout = 32'h0; writedata = 32'h0;
    sw = 16'h0; cur_sw = 16'h0; last_irq = 1'b0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("init_led", {16'h0, led}, 32'h0);
    check_eq("init_irq", {31'h0, timer_irq}, 32'h0);
    aluout = 32'h0000_F018; #1; check_eq("init_tcount", readdata, 32'h0);
    aluout = 32'h0000_F010; #1; check_eq("init_tctrl", readdata, 32'h0);
    aluout = 32'h0000_F014; #1; check_eq("init_tload", readdata, 32'h0);
    aluout = 32'h0000_F004; #1; check_eq("init_sw", readdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    model_edge(1'b0, aluout, writedata, sw);

    // fill RAM so every word has a known value
    for (int unsigned i = 0; i < 2**AW; i++) wr(32'(i << 2), $urandom);

    // RAM store/load, unmapped access, index-bound aliasing
    wr(32'h0000_0010, 32'hDEADBEEF);
    rd_bus(32'h0000_0010, r); check_eq("ram_store_load", r, 32'hDEADBEEF);
    rd_bus(32'h0001_0010, r); check_eq("unmapped_read", r, 32'h0);
    wr(32'h0001_0010, 32'h5555_5555);
    rd_bus(32'h0000_0010, r); check_eq("unmapped_write_ignored", r, 32'hDEADBEEF);
    wr(32'h0000_0000, 32'hCAFE0000);
    wr(32'h0000_0400, 32'h1111_1111);
    rd_bus(32'h0000_0000, r); check_eq("ram_no_alias", r, 32'hCAFE0000);
    rd_bus(32'h0000_0400, r); check_eq("ram_idx_hi_unmapped", r, 32'h0);
    wr(32'h0000_03FF, 32'h0BADF00D);
    rd_bus(32'h0000_03FC, r); check_eq("ram_last_word", r, 32'h0BADF00D);

    // LED register
    wr(32'h0000_F000, 32'h1234_A5A5);
    rd_bus(32'h0000_F000, r); check_eq("led_read", r, 32'h0000_A5A5);
    check_eq("led_out", {16'h0, led}, 32'h0000_A5A5);
    async_reset(pc, pi);

    // switch synchronizer latency
    cur_sw = 16'h00FF;
    rd_bus(32'h0000_F004, r); check_eq("sw_edge0", r, 32'h0);
    rd_bus(32'h0000_F004, r); check_eq("sw_edge1", r, 32'h0);
    rd_bus(32'h0000_F004, r); check_eq("sw_edge2", r, 32'h0000_00FF);
    wr(32'h0000_F004, 32'hFFFF_0000);
    rd_bus(32'h0000_F004, r); check_eq("sw_readonly", r, 32'h0000_00FF);

    // periodic timer
    wr(32'h0000_F014, 32'd5);
    wr(32'h0000_F010, 32'hB);
    for (int unsigned i = 0; i < 6; i++) begin
      rd_bus(32'h0000_F018, r);
      check_eq("periodic_count", r, seq_per[i]);
    end
    check_eq("periodic_irq", {31'h0, last_irq}, 32'h1);
    rd_bus(32'h0000_F010, r); check_eq("periodic_status", r, 32'hF);
    wr(32'h0000_F010, 32'hF);
    rd_bus(32'h0000_F010, r); check_eq("w1c_status", r, 32'hB);
    check_eq("w1c_irq", {31'h0, last_irq}, 32'h0);
    wr(32'h0000_F010, 32'h0);

    // one-shot timer
    wr(32'h0000_F014, 32'd3);
    wr(32'h0000_F010, 32'h9);
    for (int unsigned i = 0; i < 4; i++) begin
      rd_bus(32'h0000_F018, r);
      check_eq("oneshot_count", r, seq_one[i]);
    end
    check_eq("oneshot_irq", {31'h0, last_irq}, 32'h1);
    wr(32'h0000_F010, 32'hD);
    for (int unsigned i = 0; i < 20; i++) begin
      rd_bus(32'h0000_F010, r);
      check_eq("oneshot_no_refire", r, 32'h9);
    end
    rd_bus(32'h0000_F018, r); check_eq("oneshot_hold0", r, 32'h0);

    // W1C on the expiry edge: set wins
    wr(32'h0000_F014, 32'd2);
    rd_bus(32'h0000_F018, r); check_eq("w1c_exp_pre", r, 32'd2);
    wr(32'h0000_F010, 32'hD);
    rd_bus(32'h0000_F010, r); check_eq("w1c_on_expiry", r, 32'hD);

    // TLOAD write on the expiry edge
    wr(32'h0000_F010, 32'hD);
    rd_bus(32'h0000_F010, r); check_eq("status_cleared", r, 32'h9);
    wr(32'h0000_F014, 32'd2);
    rd_bus(32'h0000_F018, r); check_eq("tload_exp_pre", r, 32'd2);
    wr(32'h0000_F014, 32'd9);
    rd_bus(32'h0000_F018, r); check_eq("tload_on_expiry_cnt", r, 32'd9);
    rd_bus(32'h0000_F010, r); check_eq("tload_on_expiry_st", r, 32'hD);

    // reset while the timer runs at count 2
    wr(32'h0000_F014, 32'd5);
    rd_bus(32'h0000_F018, r); check_eq("pre_rst_5", r, 32'd5);
    rd_bus(32'h0000_F018, r); check_eq("pre_rst_4", r, 32'd4);
    rd_bus(32'h0000_F018, r); check_eq("pre_rst_3", r, 32'd3);
    async_reset(pc, pi);
    check_eq("pre_rst_cnt2", pc, 32'd2);
    check_eq("pre_rst_irq", {31'h0, pi}, 32'h1);
    for (int unsigned i = 0; i < 3; i++) begin
      rd_bus(32'h0000_F018, r);
      check_eq("post_rst_count", r, 32'h0);
    end

    // randomized traffic against the model
    for (int unsigned i = 0; i < 800; i++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic        we;
      we = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      cur_sw = 16'($urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 2**AW - 1) << 2) | ($urandom & 32'h3);
        4: a = 32'h0000_F000;
        5: a = 32'h0000_F004;
        6: a = 32'h0000_F010;
        7: begin a = 32'h0000_F014; d = 32'($urandom_range(0, 12)); end
        8: a = 32'h0000_F018;
        default: begin
          case ($urandom_range(0, 3))
            0: a = $urandom | 32'h0001_0000;
            1: a = 32'h0000_F000 | ($urandom & 32'h0000_0FFF);
            2: a = 32'h0000_0400 | ($urandom & 32'h0000_0FFF);
            default: a = 32'h0000_1000 | ($urandom & 32'h0000_EFFF);
          endcase
          if (region(a) == R_TLOAD) d = 32'($urandom_range(0, 12));
        end
      endcase
      cycle(we, a, d, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
